// File: rtl/adc_stream_unpack.sv
// Unpacks timestamped 0xDD ADC packets from a 64-bit stream into 32-bit sample records,
// one per cycle, and counts clean packets plus ID and framing errors.
module adc_stream_unpack #(
    parameter logic [7:0] ID        = 8'hDD,
    parameter int         MAX_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [63:0] in_tdata,
    input  logic        in_tfirst,
    input  logic        in_tlast,
    input  logic        in_tvalid,
    output logic        in_tready,
    output logic [17:0] out_data,
    output logic [2:0]  out_block,
    output logic [6:0]  out_rate_div,
    output logic [3:0]  out_ch,
    output logic [63:0] out_ts,
    output logic        out_first,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pkt_cnt,
    output logic [15:0] err_id_cnt,
    output logic [15:0] err_len_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_TS, S_PAYLOAD, S_DROP} state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d, wcnt_q, wcnt_d;
    logic [63:0] ts_q, ts_d, out_ts_q, out_ts_d;
    logic [31:0] rec_q, rec_d, lo_q, lo_d;
    logic        out_valid_q, out_valid_d, half_q, half_d;
    logic        out_first_q, out_first_d, out_last_q, out_last_d;
    logic        last_pend_q, last_pend_d, clean_pend_q, clean_pend_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_id_q, err_id_d, err_len_q, err_len_d;

    logic        in_fire, out_fire, hdr_id_ok, hdr_len_ok, word_is_n;
    logic        word_fire, err_id_inc, err_len_inc;
    logic [15:0] hdr_n, wnum;

    // Output stage holds the current record in rec_q and the pending later record in lo_q.
    assign in_tready  = !rst && (!ena || state_q != S_PAYLOAD || !out_valid_q
                                 || (!half_q && out_ready));
    assign in_fire    = in_tvalid && in_tready;
    assign out_fire   = out_valid_q && out_ready;
    assign hdr_n      = in_tdata[47:32];
    assign hdr_id_ok  = in_tdata[63:56] == ID;
    assign hdr_len_ok = (hdr_n != 16'd0) && ({1'b0, hdr_n} <= MAX_W);
    assign wnum       = wcnt_q + 16'd1;
    assign word_is_n  = wnum == n_q;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        wcnt_d       = wcnt_q;
        ts_d         = ts_q;
        out_ts_d     = out_ts_q;
        rec_d        = rec_q;
        lo_d         = lo_q;
        out_valid_d  = out_valid_q;
        half_d       = half_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;
        last_pend_d  = last_pend_q;
        clean_pend_d = clean_pend_q;
        pkt_cnt_d    = pkt_cnt_q;
        err_id_d     = err_id_q;
        err_len_d    = err_len_q;
        word_fire    = 1'b0;
        err_id_inc   = 1'b0;
        err_len_inc  = 1'b0;

        if (out_fire) begin
            if (half_q) begin
                rec_d       = lo_q;
                half_d      = 1'b0;
                out_first_d = 1'b0;
                out_last_d  = last_pend_q;
            end else begin
                out_valid_d  = 1'b0;
                out_first_d  = 1'b0;
                out_last_d   = 1'b0;
                last_pend_d  = 1'b0;
                clean_pend_d = 1'b0;
                if (clean_pend_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_fire && in_tfirst) begin
                    // A one-beat bad header has no tail to drop; stay ready for the next header.
                    if (!hdr_id_ok) begin
                        err_id_inc = 1'b1;
                        state_d    = in_tlast ? S_IDLE : S_DROP;
                    end else if (!hdr_len_ok) begin
                        err_len_inc = 1'b1;
                        state_d     = in_tlast ? S_IDLE : S_DROP;
                    end else begin
                        n_d     = hdr_n;
                        wcnt_d  = 16'd0;
                        state_d = S_TS;
                    end
                end
            end
            S_TS: begin
                if (in_fire) begin
                    if (in_tlast || in_tfirst) begin
                        err_len_inc = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        ts_d    = in_tdata;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (in_fire) begin
                    if (in_tfirst) begin
                        err_len_inc = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        word_fire = 1'b1;
                        wcnt_d    = wnum;
                        if (in_tlast) begin
                            err_len_inc = !word_is_n;
                            state_d     = S_IDLE;
                        end else if (word_is_n) begin
                            err_len_inc = 1'b1;
                            state_d     = S_DROP;
                        end
                    end
                end
            end
            S_DROP: begin
                if (in_fire && in_tlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (word_fire) begin
            out_valid_d  = 1'b1;
            rec_d        = in_tdata[63:32];
            lo_d         = in_tdata[31:0];
            half_d       = 1'b1;
            out_first_d  = wcnt_q == 16'd0;
            out_last_d   = 1'b0;
            last_pend_d  = in_tlast || word_is_n;
            clean_pend_d = in_tlast && word_is_n;
            out_ts_d     = ts_q;
        end

        if (err_id_inc && err_id_q != 16'hFFFF)   err_id_d  = err_id_q + 16'd1;
        if (err_len_inc && err_len_q != 16'hFFFF) err_len_d = err_len_q + 16'd1;

        if (!ena) begin
            state_d      = S_IDLE;
            rec_d        = 32'd0;
            lo_d         = 32'd0;
            out_valid_d  = 1'b0;
            half_d       = 1'b0;
            out_first_d  = 1'b0;
            out_last_d   = 1'b0;
            last_pend_d  = 1'b0;
            clean_pend_d = 1'b0;
            pkt_cnt_d    = pkt_cnt_q;
            err_id_d     = err_id_q;
            err_len_d    = err_len_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            wcnt_q       <= '0;
            ts_q         <= '0;
            out_ts_q     <= '0;
            rec_q        <= '0;
            lo_q         <= '0;
            out_valid_q  <= 1'b0;
            half_q       <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            last_pend_q  <= 1'b0;
            clean_pend_q <= 1'b0;
            pkt_cnt_q    <= '0;
            err_id_q     <= '0;
            err_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            wcnt_q       <= wcnt_d;
            ts_q         <= ts_d;
            out_ts_q     <= out_ts_d;
            rec_q        <= rec_d;
            lo_q         <= lo_d;
            out_valid_q  <= out_valid_d;
            half_q       <= half_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            last_pend_q  <= last_pend_d;
            clean_pend_q <= clean_pend_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_id_q     <= err_id_d;
            err_len_q    <= err_len_d;
        end
    end

    assign out_data     = rec_q[31:14];
    assign out_block    = rec_q[13:11];
    assign out_rate_div = rec_q[10:4];
    assign out_ch       = rec_q[3:0];
    assign out_ts       = out_ts_q;
    assign out_first    = out_first_q;
    assign out_last     = out_last_q;
    assign out_valid    = out_valid_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign err_id_cnt   = err_id_q;
    assign err_len_cnt  = err_len_q;
endmodule

// File: tb/tb_adc_stream_unpack.sv
// Directed bench for adc_stream_unpack: clean, stalled, bad-ID, short, long, ena-gap and reset packets.
module tb_adc_stream_unpack;
    localparam logic [63:0] W0 = 64'hAAAA_0001_BBBB_0002;
    localparam logic [63:0] W1 = 64'hCCCC_0003_DDDD_0004;

    logic        clk = 1'b0;
    logic        rst, ena, in_tfirst, in_tlast, in_tvalid, in_tready;
    logic [63:0] in_tdata, out_ts;
    logic [17:0] out_data;
    logic [2:0]  out_block;
    logic [6:0]  out_rate_div;
    logic [3:0]  out_ch;
    logic        out_first, out_last, out_valid, out_ready;
    logic [31:0] pkt_cnt;
    logic [15:0] err_id_cnt, err_len_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_viol = 0;
    logic toggle_mode = 1'b0;

    logic [31:0] q_rec[$];
    logic [63:0] q_ts[$];
    logic        q_first[$];
    logic        q_last[$];
    int          q_cyc[$];
    logic [31:0] exp_rec[4];

    adc_stream_unpack dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_tdata(in_tdata), .in_tfirst(in_tfirst), .in_tlast(in_tlast),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_data(out_data), .out_block(out_block), .out_rate_div(out_rate_div),
        .out_ch(out_ch), .out_ts(out_ts), .out_first(out_first), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .pkt_cnt(pkt_cnt), .err_id_cnt(err_id_cnt), .err_len_cnt(err_len_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (toggle_mode) out_ready = ~out_ready;
    end

    // Record every accepted sample and note any output change while stalled.
    logic        stalled_prev = 1'b0;
    logic [31:0] s_rec;
    logic [63:0] s_ts;
    logic        s_first, s_last;
    always @(negedge clk) begin
        if (stalled_prev && ({out_data, out_block, out_rate_div, out_ch} !== s_rec ||
            out_ts !== s_ts || out_first !== s_first || out_last !== s_last || out_valid !== 1'b1))
            stall_viol++;
        if (out_valid && out_ready) begin
            q_rec.push_back({out_data, out_block, out_rate_div, out_ch});
            q_ts.push_back(out_ts);
            q_first.push_back(out_first);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
        stalled_prev = out_valid && !out_ready;
        s_rec   = {out_data, out_block, out_rate_div, out_ch};
        s_ts    = out_ts;
        s_first = out_first;
        s_last  = out_last;
    end

    function automatic logic [63:0] hdr(input logic [7:0] id, input logic [15:0] n);
        return {id, 8'h00, n, 32'h0};
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic f, input logic l);
        bit ok, got;
        in_tdata = d; in_tfirst = f; in_tlast = l; in_tvalid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            ok = in_tready;
            @(posedge clk);
            if (ok) got = 1'b1;
        end
        #1;
        in_tvalid = 1'b0; in_tfirst = 1'b0; in_tlast = 1'b0;
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept: beat %h not accepted in 50 cycles, required acceptance", d);
        end
    endtask

    task automatic send_good(input logic [63:0] ts);
        send_beat(hdr(8'hDD, 16'd2), 1'b1, 1'b0);
        send_beat(ts, 1'b0, 1'b0);
        send_beat(W0, 1'b0, 1'b0);
        send_beat(W1, 1'b0, 1'b1);
    endtask

    task automatic clear_q;
        q_rec.delete(); q_ts.delete(); q_first.delete(); q_last.delete(); q_cyc.delete();
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b want 0", in_tready); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready: got %b want 1", in_tready); end
        checks++;
        if ({out_valid, out_first, out_last} !== 3'b000 || out_data !== 18'd0 || out_ts !== 64'd0 || out_ch !== 4'd0) begin
            errors++; $display("FAIL rst_outputs: valid/first/last=%b data=%h ts=%h want zeros", {out_valid, out_first, out_last}, out_data, out_ts);
        end
        checks++;
        if (pkt_cnt !== 32'd0 || err_id_cnt !== 16'd0 || err_len_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_counters: pkt=%0d id=%0d len=%0d want 0", pkt_cnt, err_id_cnt, err_len_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        clear_q();
        send_beat(hdr(8'hDD, 16'd2), 1'b1, 1'b0);
        send_beat(64'h1234, 1'b0, 1'b0);
        send_beat(W0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_first !== 1'b1 || out_ch !== 4'd1) begin
            errors++; $display("FAIL hi_latency: valid=%b first=%b ch=%0d want 1 1 1", out_valid, out_first, out_ch);
        end
        send_beat(W1, 1'b0, 1'b1);
        drain(20);
        checks++;
        if (q_rec.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d want 4", q_rec.size()); end
        for (int i = 0; i < 4 && i < q_rec.size(); i++) begin
            checks++;
            if (q_rec[i] !== exp_rec[i] || q_rec[i][3:0] !== 4'(i + 1) || q_ts[i] !== 64'h1234 ||
                q_first[i] !== (i == 0) || q_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL basic_rec%0d: rec=%h ts=%h f=%b l=%b want rec=%h ts=1234 f=%b l=%b",
                         i, q_rec[i], q_ts[i], q_first[i], q_last[i], exp_rec[i], i == 0, i == 3);
            end
        end
        if (q_cyc.size() == 4) begin
            checks++;
            if (q_cyc[3] - q_cyc[0] !== 3) begin errors++; $display("FAIL basic_throughput: span %0d want 3", q_cyc[3] - q_cyc[0]); end
        end
        checks++;
        if (pkt_cnt !== 32'd1 || err_id_cnt !== 16'd0 || err_len_cnt !== 16'd0) begin
            errors++; $display("FAIL basic_counters: pkt=%0d id=%0d len=%0d want 1 0 0", pkt_cnt, err_id_cnt, err_len_cnt);
        end
    endtask

    task automatic test_stall;
        clear_q();
        stall_viol = 0;
        toggle_mode = 1'b1;
        send_good(64'h5678);
        drain(40);
        toggle_mode = 1'b0;
        out_ready = 1'b1;
        drain(4);
        checks++;
        if (q_rec.size() !== 4) begin errors++; $display("FAIL stall_count: got %0d want 4", q_rec.size()); end
        for (int i = 0; i < 4 && i < q_rec.size(); i++) begin
            checks++;
            if (q_rec[i] !== exp_rec[i] || q_ts[i] !== 64'h5678 || q_first[i] !== (i == 0) || q_last[i] !== (i == 3)) begin
                errors++; $display("FAIL stall_rec%0d: rec=%h ts=%h want rec=%h ts=5678", i, q_rec[i], q_ts[i], exp_rec[i]);
            end
        end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable: %0d changes while stalled, want 0", stall_viol); end
        checks++;
        if (pkt_cnt !== 32'd2) begin errors++; $display("FAIL stall_pkt: got %0d want 2", pkt_cnt); end
    endtask

    task automatic test_bad_id;
        clear_q();
        send_beat(hdr(8'h55, 16'd1), 1'b1, 1'b0);
        send_beat(64'h1111, 1'b0, 1'b0);
        send_beat(64'h2222, 1'b0, 1'b1);
        drain(10);
        checks++;
        if (q_rec.size() !== 0 || err_id_cnt !== 16'd1 || pkt_cnt !== 32'd2) begin
            errors++; $display("FAIL bad_id: recs=%0d id=%0d pkt=%0d want 0 1 2", q_rec.size(), err_id_cnt, pkt_cnt);
        end
        send_good(64'h9ABC);
        drain(20);
        checks++;
        if (q_rec.size() !== 4 || pkt_cnt !== 32'd3 || err_id_cnt !== 16'd1) begin
            errors++; $display("FAIL bad_id_next: recs=%0d pkt=%0d id=%0d want 4 3 1", q_rec.size(), pkt_cnt, err_id_cnt);
        end else begin
            checks++;
            if (q_rec[3] !== exp_rec[3] || q_last[3] !== 1'b1 || q_ts[0] !== 64'h9ABC) begin
                errors++; $display("FAIL bad_id_rec: rec3=%h last=%b ts=%h want %h 1 9abc", q_rec[3], q_last[3], q_ts[0], exp_rec[3]);
            end
        end
    endtask

    task automatic test_short;
        clear_q();
        send_beat(hdr(8'hDD, 16'd3), 1'b1, 1'b0);
        send_beat(64'h42, 1'b0, 1'b0);
        send_beat(W0, 1'b0, 1'b0);
        send_beat(W1, 1'b0, 1'b1);
        drain(20);
        checks++;
        if (q_rec.size() !== 4) begin errors++; $display("FAIL short_count: got %0d want 4", q_rec.size()); end
        for (int i = 0; i < 4 && i < q_rec.size(); i++) begin
            checks++;
            if (q_rec[i] !== exp_rec[i] || q_first[i] !== (i == 0) || q_last[i] !== (i == 3)) begin
                errors++; $display("FAIL short_rec%0d: rec=%h f=%b l=%b want %h %b %b", i, q_rec[i], q_first[i], q_last[i], exp_rec[i], i == 0, i == 3);
            end
        end
        checks++;
        if (err_len_cnt !== 16'd1 || pkt_cnt !== 32'd3) begin
            errors++; $display("FAIL short_counters: len=%0d pkt=%0d want 1 3", err_len_cnt, pkt_cnt);
        end
    endtask

    task automatic test_long;
        clear_q();
        send_beat(hdr(8'hDD, 16'd1), 1'b1, 1'b0);
        send_beat(64'h77, 1'b0, 1'b0);
        send_beat(W0, 1'b0, 1'b0);
        send_beat(W1, 1'b0, 1'b1);
        drain(20);
        checks++;
        if (q_rec.size() !== 2) begin
            errors++; $display("FAIL long_count: got %0d want 2", q_rec.size());
        end else begin
            checks++;
            if (q_rec[0] !== exp_rec[0] || q_rec[1] !== exp_rec[1] || q_last[0] !== 1'b0 || q_last[1] !== 1'b1) begin
                errors++; $display("FAIL long_recs: %h/%b %h/%b want %h/0 %h/1", q_rec[0], q_last[0], q_rec[1], q_last[1], exp_rec[0], exp_rec[1]);
            end
        end
        checks++;
        if (err_len_cnt !== 16'd2 || pkt_cnt !== 32'd3) begin
            errors++; $display("FAIL long_counters: len=%0d pkt=%0d want 2 3", err_len_cnt, pkt_cnt);
        end
        clear_q();
        send_good(64'h88);
        drain(20);
        checks++;
        if (q_rec.size() !== 4 || pkt_cnt !== 32'd4 || err_len_cnt !== 16'd2) begin
            errors++; $display("FAIL long_next: recs=%0d pkt=%0d len=%0d want 4 4 2", q_rec.size(), pkt_cnt, err_len_cnt);
        end
    endtask

    task automatic test_ena;
        clear_q();
        send_beat(hdr(8'hDD, 16'd2), 1'b1, 1'b0);
        send_beat(64'h99, 1'b0, 1'b0);
        ena = 1'b0;
        send_beat(W0, 1'b0, 1'b0);
        ena = 1'b1;
        send_beat(W1, 1'b0, 1'b1);
        drain(10);
        checks++;
        if (q_rec.size() !== 0 || pkt_cnt !== 32'd4 || err_id_cnt !== 16'd1 || err_len_cnt !== 16'd2) begin
            errors++; $display("FAIL ena_gap: recs=%0d pkt=%0d id=%0d len=%0d want 0 4 1 2", q_rec.size(), pkt_cnt, err_id_cnt, err_len_cnt);
        end
        send_good(64'hAB);
        drain(20);
        checks++;
        if (q_rec.size() !== 4 || pkt_cnt !== 32'd5 || err_len_cnt !== 16'd2) begin
            errors++; $display("FAIL ena_next: recs=%0d pkt=%0d len=%0d want 4 5 2", q_rec.size(), pkt_cnt, err_len_cnt);
        end else begin
            checks++;
            if (q_ts[0] !== 64'hAB || q_rec[0] !== exp_rec[0] || q_first[0] !== 1'b1) begin
                errors++; $display("FAIL ena_rec0: rec=%h ts=%h first=%b want %h ab 1", q_rec[0], q_ts[0], q_first[0], exp_rec[0]);
            end
        end
    endtask

    task automatic test_rst_mid;
        send_beat(hdr(8'hDD, 16'd2), 1'b1, 1'b0);
        send_beat(64'h55, 1'b0, 1'b0);
        send_beat(W0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %b want 0", in_tready); end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || pkt_cnt !== 32'd0 || err_id_cnt !== 16'd0 || err_len_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_rst_clear: valid=%b pkt=%0d id=%0d len=%0d want 0 0 0 0", out_valid, pkt_cnt, err_id_cnt, err_len_cnt);
        end
        @(posedge clk); #1;
        send_beat(W1, 1'b0, 1'b1);
        drain(10);
        checks++;
        if (q_rec.size() !== 0) begin errors++; $display("FAIL mid_rst_discard: recs=%0d want 0", q_rec.size()); end
    endtask

    initial begin
        exp_rec[0] = 32'hAAAA_0001; exp_rec[1] = 32'hBBBB_0002;
        exp_rec[2] = 32'hCCCC_0003; exp_rec[3] = 32'hDDDD_0004;
        rst = 1'b1; ena = 1'b1; in_tdata = '0; in_tfirst = 1'b0; in_tlast = 1'b0;
        in_tvalid = 1'b0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_bad_id();
        test_short();
        test_long();
        test_ena();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in 200000 time units");
        $fatal(1);
    end
endmodule

// File: doc/adc_stream_unpack.md
# adc_stream_unpack

Receive-side counterpart of the ADC sample streamer: consumes timestamped 64-bit ADC data packets (ID 0xDD) from an AXI-stream FIFO and unpacks each payload word into two 32-bit sample records, emitting one sample per cycle with its packet timestamp. It sits downstream of the stream FIFO (loopback and self-test paths, and host-side capture logic) and checks packet framing, counting ID and length errors.

## Interface
- ID, 8'hDD: expected packet ID in header byte [63:56].
- MAX_WORDS, 8192: maximum legal payload word count N.
- clk  in  1  single clock.
- rst  in  1  reset, synchronous and active-high.
- ena  in  1  unpacker enable.
- in_tdata  in  64  stream word.
- in_tfirst  in  1  first beat of packet (header).
- in_tlast  in  1  last beat of packet.
- in_tvalid  in  1  beat valid.
- in_tready  out  1  beat accepted when in_tvalid && in_tready.
- out_data  out  18  ADC sample.
- out_block  out  3  block field.
- out_rate_div  out  7  rate divider field.
- out_ch  out  4  channel number.
- out_ts  out  64  timestamp of the packet carrying this sample.
- out_first  out  1  first sample of packet.
- out_last  out  1  last sample of packet.
- out_valid  out  1  sample valid.
- out_ready  in  1  sample accepted when out_valid && out_ready.
- pkt_cnt  out  32  clean packets completed (wraps).
- err_id_cnt  out  16  ID mismatches (saturating).
- err_len_cnt  out  16  length/framing errors (saturating).

## Operation
- Packet format: beat 0 (tfirst=1) header: [63:56] ID, [55:48] reserved, [47:32] N payload words, [31:0] ignored. Beat 1: timestamp[63:0]. Beats 2..N+1: payload; beat N+1 carries tlast.
- Payload word: [63:32] earlier record, [31:0] later record. Record = {data[31:14], block[13:11], rate_div[10:4], ch[3:0]}.
- States: IDLE, TS, PAYLOAD, DROP.
- IDLE: in_tready=1; beat with tfirst: ID match and 1<=N<=MAX_WORDS -> latch N, TS; ID mismatch -> err_id_cnt++, DROP (or stay IDLE if that beat has tlast); bad N -> err_len_cnt++, DROP. Beats without tfirst discarded.
- TS: in_tready=1; latch timestamp, PAYLOAD. tlast or tfirst on this beat -> err_len_cnt++, IDLE (tfirst beat reprocessed as header next cycle is NOT done; it is dropped).
- PAYLOAD: 64-bit hold register with half flag. in_tready = !hold_valid || (half==LO && out_ready). Accepted word loads hold, half=HI. Each out handshake advances HI->LO->empty.
- Word count: tlast on word N -> clean; last LO record gets out_last=1, pkt_cnt++ when it is accepted, IDLE.
- tlast before word N -> err_len_cnt++, that word's LO record gets out_last=1, IDLE, no pkt_cnt.
- Word N without tlast -> err_len_cnt++, out_last on its LO record, DROP.
- tfirst on any payload beat -> err_len_cnt++, beat discarded, DROP exit not needed: go to IDLE after pending records drain.
- DROP: in_tready=1; discard until tlast accepted, then IDLE.
- out_first=1 on HI record of first payload word only.
- ena=0: in_tready=1, all beats discarded, hold cleared, out_valid=0, state IDLE; on ena rise, unpacking resumes at next tfirst. Counters hold.

## Timing
- Reset: state IDLE, in_tready=0 during rst cycle then 1, out_valid/out_first/out_last=0, out_data/out_ts/fields=0, all counters 0.
- Outputs registered. HI record valid the cycle after its payload word is accepted; LO record follows on the cycle after HI handshake.
- Throughput: 1 sample/cycle with out_ready=1; input sustains 1 word per 2 cycles.
- Outputs stable while out_valid && !out_ready.
- Counter increment cycle after the triggering beat/handshake; saturate at 16'hFFFF.
- rst mid-packet: everything cleared; next data only after a new tfirst.

## Test plan
- Header ID=DD, N=2, ts=0x1234, words 0xAAAA_0001_BBBB_0002, 0xCCCC_0003_DDDD_0004 (tlast) -> 4 records in order, ch=1,2,3,4, out_ts=0x1234, first on rec 0, last on rec 3, pkt_cnt=1.
- Same packet, out_ready toggled 1/0 each cycle -> identical record sequence, no loss, outputs stable when stalled.
- Header ID=0x55 N=1, two beats, tlast -> no output, err_id_cnt=1; following good packet unpacks normally.
- N=3 but tlast on word 2 -> 4 records, out_last on rec 3, err_len_cnt=1, pkt_cnt unchanged.
- N=1, two payload words then tlast -> 2 records, err_len_cnt=1, second word discarded, next packet clean.
- ena dropped after header, raised mid-payload -> no output until next tfirst; next packet clean, counters unchanged.
